// File: rtl/conv_pkg.sv
// Shared constants, memory-select encodings and FSM state codes for the CONV accelerator.
// Also holds the signed max helper used by the pooling stages.
package conv_pkg;

  localparam int IMG_W  = 64;
  localparam int POOL_W = IMG_W / 2;
  localparam int DW     = 20;
  localparam int AW     = 12;
  localparam int PW     = $clog2(POOL_W);

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_LAST  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Ties keep the stored value, so the result is always one of the inputs.
  function automatic logic [DW-1:0] smax(input logic [DW-1:0] keep,
                                         input logic [DW-1:0] cand);
    return ($signed(cand) > $signed(keep)) ? cand : keep;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Row/column/window counters for 2x2 stride-2 pooling; addresses are pure bit
// concatenations of the counters, so no multipliers are needed.
module pool_addr_gen
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          k_step,
  input  logic          pix_step,
  output logic [1:0]    k,
  output logic          last_k,
  output logic          last_pix,
  output logic [AW-1:0] caddr_rd,
  output logic [AW-1:0] caddr_wr
);

  logic [PW-1:0] r_reg;
  logic [PW-1:0] c_reg;
  logic [1:0]    k_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg <= '0;
      c_reg <= '0;
      k_reg <= '0;
    end else if (clear) begin
      r_reg <= '0;
      c_reg <= '0;
      k_reg <= '0;
    end else begin
      if (k_step) begin
        k_reg <= k_reg + 2'd1;
      end
      // r advances only when c wraps from its last column.
      if (pix_step) begin
        {r_reg, c_reg} <= {r_reg, c_reg} + (2*PW)'(1);
      end
    end
  end

  assign k        = k_reg;
  assign last_k   = (k_reg == 2'd3);
  assign last_pix = (&r_reg) && (&c_reg);

  // Source (2r+k1)*IMG_W + 2c+k0, written as a bit layout.
  assign caddr_rd = AW'({r_reg, k_reg[1], c_reg, k_reg[0]});
  assign caddr_wr = AW'({r_reg, c_reg});

endmodule

// File: rtl/maxpool_l1.sv
// Layer-1 2x2 max pooling: reads layer-0 memory, writes the pooled 32x32 map to layer-1.
// Outputs are registered from the next state, so each bus phase lags its FSM decision by one edge.
module maxpool_l1
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  state_t        state_reg;
  state_t        state_next;
  logic          busy_next;
  logic [DW-1:0] max_reg;
  logic [1:0]    k;
  logic          last_k;
  logic          last_pix;
  logic          accept;

  assign accept = (state_reg == ST_IDLE) && start && !busy;

  pool_addr_gen u_addr (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .k_step   (state_reg == ST_READ),
    .pix_step (state_reg == ST_WRITE),
    .k        (k),
    .last_k   (last_k),
    .last_pix (last_pix),
    .caddr_rd (caddr_rd),
    .caddr_wr (caddr_wr)
  );

  // IDLE with busy set is the one-cycle arm slot between start and the first read.
  always_comb begin
    state_next = state_reg;
    busy_next  = busy;
    case (state_reg)
      ST_IDLE: begin
        if (busy) begin
          state_next = ST_READ;
        end else if (start) begin
          busy_next = 1'b1;
        end
      end
      ST_READ:  if (last_k) state_next = ST_LAST;
      ST_LAST:  state_next = ST_WRITE;
      ST_WRITE: state_next = last_pix ? ST_DONE : ST_READ;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (state_next == ST_DONE) begin
      busy_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      crd       <= 1'b0;
      cwr       <= 1'b0;
      csel      <= CSEL_NONE;
      max_reg   <= '0;
      cdata_wr  <= '0;
    end else begin
      state_reg <= state_next;
      busy      <= busy_next;
      done      <= (state_next == ST_DONE);
      crd       <= (state_next == ST_READ);
      cwr       <= (state_next == ST_WRITE);
      case (state_next)
        ST_READ, ST_LAST: csel <= CSEL_L0;
        ST_WRITE:         csel <= CSEL_L1;
        default:          csel <= CSEL_NONE;
      endcase
      // Sample k-1 is on cdata_rd while the bus shows read k; sample 0 loads unconditionally.
      if (state_reg == ST_READ) begin
        if (k == 2'd1) begin
          max_reg <= cdata_rd;
        end else if (k != 2'd0) begin
          max_reg <= smax(max_reg, cdata_rd);
        end
      end
      if (state_reg == ST_LAST) begin
        cdata_wr <= smax(max_reg, cdata_rd);
      end
    end
  end

endmodule

// File: tb/tb_maxpool_l1.sv
// Scoreboard bench for maxpool_l1: layer-0 memory model, expected layer-1 queue, bus checks.
`timescale 1ns/1ps
module tb_maxpool_l1;
  import conv_pkg::*;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0 [0:4095];
  logic [DW-1:0] l1 [0:1023];
  exp_t          exp_q[$];
  int            n_chk;
  int            n_pass;
  int            n_wr;
  int            n_done;

  maxpool_l1 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer-0 memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (crd) cdata_rd <= l0[caddr_rd];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("rd_wr_excl", {63'd0, crd & cwr}, 64'd0);
    if (crd | cwr) chk("csel", {61'd0, csel}, {61'd0, (crd ? CSEL_L0 : CSEL_L1)});
    if (done) n_done++;
    if (cwr) begin
      n_wr++;
      l1[caddr_wr[9:0]] = cdata_wr;
      if (exp_q.size() == 0) begin
        chk("sb_depth", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(caddr_wr), 64'(e.addr));
        chk("wr_data", 64'(cdata_wr), 64'(e.data));
      end
    end
  end

  task automatic push_expected();
    exp_t e;
    logic signed [DW-1:0] m;
    logic signed [DW-1:0] s;
    int base;
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        base = (2 * r) * 64 + 2 * c;
        m = l0[base];
        s = l0[base + 1];  if (s > m) m = s;
        s = l0[base + 64]; if (s > m) m = s;
        s = l0[base + 65]; if (s > m) m = s;
        e.addr = AW'(r * 32 + c);
        e.data = m;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_win(input int r, input int c, input logic [DW-1:0] v0,
                         input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                         input logic [DW-1:0] v3);
    l0[(2 * r) * 64 + 2 * c]         = v0;
    l0[(2 * r) * 64 + 2 * c + 1]     = v1;
    l0[(2 * r + 1) * 64 + 2 * c]     = v2;
    l0[(2 * r + 1) * 64 + 2 * c + 1] = v3;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 4096; a++) l0[a] = DW'($urandom);
    for (int a = 0; a < 1024; a++) l1[a] = '0;
  endtask

  // mode 0: plain layer, 1: extra start pulses mid-run, 2: reset at cycle 3000.
  task automatic run_layer(input int mode, input string name);
    int cyc;
    int wr_at_rst;
    bit aborted;
    push_expected();
    n_wr = 0;
    n_done = 0;
    aborted = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_rise", {63'd0, busy}, 64'd1);
    chk("first_read_lag", {63'd0, crd}, 64'd0);
    cyc = 0;
    while (!done && !aborted && cyc < 7000) begin
      @(negedge clk);
      cyc++;
      start = (mode == 1) && (cyc == 100 || cyc == 4000);
      if (mode == 2 && cyc == 3000) begin
        reset = 1'b1;
        #1;
        chk("rst_outputs", 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
        wr_at_rst = n_wr;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("no_wr_after_rst", 64'(n_wr), 64'(wr_at_rst));
        chk("idle_after_rst", {62'd0, busy, crd}, 64'd0);
        exp_q.delete();
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("done_latency", 64'(cyc), 64'd6145);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("done_width", {63'd0, done}, 64'd0);
      chk("write_count", 64'(n_wr), 64'd1024);
      chk("done_count", 64'(n_done), 64'd1);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
    end
    $display("layer %s: mode=%0d cycles=%0d writes=%0d done_pulses=%0d", name, mode, cyc, n_wr, n_done);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    n_wr = 0;
    n_done = 0;
    reset = 1'b1;
    start = 1'b0;
    cdata_rd = '0;
    #1;
    chk("reset_ctrl", {60'd0, busy, done, crd, cwr}, 64'd0);
    chk("reset_csel", {61'd0, csel}, 64'd0);
    chk("reset_addr", 64'({caddr_rd, caddr_wr}), 64'd0);
    chk("reset_wdata", 64'(cdata_wr), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
    for (int a = 0; a < 1024; a++) l1[a] = '0;
    run_layer(0, "ramp");
    chk("ramp_l1_first", 64'(l1[0]), 64'h00041);
    chk("ramp_l1_last", 64'(l1[1023]), 64'h00FFF);

    fill_random();
    for (int p = 0; p < 4; p++) begin
      set_win(0, p, (p == 0) ? 20'h7FFFF : 20'h0, (p == 1) ? 20'h7FFFF : 20'h0,
              (p == 2) ? 20'h7FFFF : 20'h0, (p == 3) ? 20'h7FFFF : 20'h0);
    end
    set_win(0, 4, 20'hFFFFF, 20'h80000, 20'hFFFFE, 20'hC0000);
    set_win(31, 31, 20'h80000, 20'h80001, 20'h80000, 20'h80000);
    run_layer(0, "corners_negative");
    for (int p = 0; p < 4; p++) chk("corner_max", 64'(l1[p]), 64'h7FFFF);
    chk("all_negative", 64'(l1[4]), 64'hFFFFF);
    chk("min_window", 64'(l1[1023]), 64'h80001);

    fill_random();
    run_layer(1, "restart_ignored");

    fill_random();
    run_layer(2, "reset_abort");
    run_layer(0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/maxpool_l1.md
# maxpool_l1

Layer-1 stage of the CONV accelerator: once the convolution/ReLU stage has filled layer-0 memory (64x64, 20-bit), this block reads it back, computes 2x2 stride-2 max pooling, and writes the 32x32 result to layer-1 memory. It sits directly downstream of the convolution stage, which triggers it with a start pulse. It shares the `csel`/`crd`/`cwr` memory port with that stage and drives the port only while busy.

## Interface
- `IMG_W`, 64: layer-0 width and height in pixels; must be a power of two.
- `DW`, 20: data width, signed fixed point 4.16.
- `AW`, 12: memory address width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock domain only.
- `start`  in  1  one-cycle pulse; begins pooling when idle.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last layer-1 write.
- `crd`  out  1  layer-0 read strobe.
- `caddr_rd`  out  AW  layer-0 read address.
- `cdata_rd`  in  DW  read data, valid exactly one cycle after `crd`/`caddr_rd`.
- `cwr`  out  1  layer-1 write strobe.
- `caddr_wr`  out  AW  layer-1 write address.
- `cdata_wr`  out  DW  layer-1 write data.
- `csel`  out  3  memory select: 3'b000 none, 3'b001 layer 0 (read), 3'b011 layer 1 (write).

## Operation
- Output pixel (r,c), with r and c each 0..31, is processed in raster order.
- Its four layer-0 sources, issued in this order (k=0..3):
  - (2r)*64+2c
  - (2r)*64+2c+1
  - (2r+1)*64+2c
  - (2r+1)*64+2c+1
- The layer-1 write address is r*32+c.
- FSM states: IDLE, READ, LAST, WRITE, DONE.
- IDLE:
  - All strobes are 0 and `csel`=000.
  - `start`=1 moves to READ, clears r, c and k, and sets `busy`.
- READ (4 cycles, k=0..3):
  - Drives `crd`=1, `csel`=001, `caddr_rd`=source k.
  - When k≥1, folds `cdata_rd` (sample k-1) into the running max.
  - After k=3, moves to LAST.
- LAST:
  - Drives `crd`=0 and `csel`=001.
  - Folds sample 3, then moves to WRITE.
- WRITE:
  - Drives `cwr`=1, `csel`=011, `caddr_wr`=r*32+c, `cdata_wr`=max.
  - Advances c; when c wraps from 31, c goes to 0 and r increments.
  - After (31,31), moves to DONE; otherwise returns to READ with k=0.
- DONE:
  - Drives `done`=1 and clears `busy` in the same cycle.
  - Returns to IDLE.
- Max arithmetic:
  - The running max is DW bits and is compared signed.
  - Sample 0 is loaded directly, never compared against 0, so all-negative windows pool correctly.
  - Ties keep the stored value.
  - No rounding or saturation; the output is bit-exact to one of the four inputs.
- `start` while busy is ignored. `ready` is handled by the convolution stage, not here.

## Timing
- Reset values:
  - `busy`, `done`, `crd`, `cwr` = 0.
  - `csel`=000.
  - `caddr_rd`, `caddr_wr`, `cdata_wr` = 0.
  - FSM in IDLE; counters r, c, k at 0.
- All outputs are registered.
- Per output pixel: 6 cycles (4 READ + LAST + WRITE).
- Full layer: 1024*6 = 6144 cycles from the first READ, plus 1 DONE cycle.
- `start` at edge t puts the first READ on the outputs after edge t+1. `done` is high for exactly one cycle.
- `crd` and `cwr` are never asserted in the same cycle, and `csel` always matches the active strobe.
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronous).
  - No further writes occur.
  - Pooling restarts only on a new `start`.
- Wrap-around:
  - The c counter is 5 bits; r increments only on the c 31→0 transition.
  - r=31 with c=31 terminates the layer, with no write beyond address 1023.

## Structure
- Shared package `conv_pkg` holds:
  - `csel` encodings: `CSEL_NONE`, `CSEL_L0`, `CSEL_L1`.
  - `IMG_W` and `POOL_W`=IMG_W/2.
  - `DW` and `AW`.
  - The FSM state typedef.
- Sub-module `pool_addr_gen`: owns the r, c, k counters and produces `caddr_rd` and `caddr_wr` by bit concatenation, with no multipliers.
- The top level holds the FSM, the running-max register and the output registers.

## Test plan
- Ramp: L0[a]=a. Required: L1[0]=0x00041 (address 65), L1[1023]=0x00FFF (address 4095), and `done` exactly 6145 cycles after `start`.
- Max in each corner position: a window with value 0x7FFFF placed at each of k=0..3 (others 0). Required: L1 entry = 0x7FFFF for every placement.
- All-negative window: samples 0xFFFFF, 0x80000, 0xFFFFE, 0xC0000. Required: L1=0xFFFFF (signed max of -1 and the rest).
- `start` pulsed again mid-run. Required: ignored; exactly 1024 writes occur and a single `done` pulse.
- Reset asserted at cycle 3000:
  - Required: all outputs are 0 within the same cycle and no `cwr` occurs afterwards.
  - Then a new `start` gives a complete, correct layer.
- Bus checker (every cycle): `crd`&`cwr` never both 1, `csel` matches the active strobe, and `caddr_wr` is strictly increasing 0..1023.
